cmd_fetch: RTL

Command-word fetcher on the SDRAM read port p1, acting as the responder side of the sequencer's command FIFO handshake. When the command sequencer raises `dma_p1_reads_en`, this block issues one 8-word read burst from the command region of SDRAM. It then streams the returned words to the sequencer on `cmd`, one `dma_p1_ob_we` strobe per word, and advances to the next 32-byte command slot. It sits between the memory-controller read port p1 and the command sequencer.

---
 rtl/cmd_fetch_if.sv | 31 +++
 rtl/cmd_fetch.sv | 95 +++++++++
 2 files changed

// File: rtl/cmd_fetch_if.sv
// Bundle of the sequencer command handshake and the SDRAM read port p1.
// The master modport is the fetcher's view; the slave modport is the environment's view.
interface cmd_fetch_if;
    logic        op_en;
    logic        dma_p1_reads_en;
    logic        dma_p1_ob_we;
    logic [31:0] cmd;
    logic [6:0]  cmd_index;
    logic        fetch_err;
    logic        p1_cmd_en;
    logic [2:0]  p1_cmd_instr;
    logic [5:0]  p1_cmd_bl;
    logic [29:0] p1_cmd_byte_addr;
    logic        p1_cmd_full;
    logic        p1_rd_en;
    logic [31:0] p1_rd_data;
    logic        p1_rd_empty;
    logic        p1_rd_error;

    modport master (
        input  op_en, dma_p1_reads_en, p1_cmd_full, p1_rd_data, p1_rd_empty, p1_rd_error,
        output dma_p1_ob_we, cmd, cmd_index, fetch_err,
               p1_cmd_en, p1_cmd_instr, p1_cmd_bl, p1_cmd_byte_addr, p1_rd_en
    );

    modport slave (
        output op_en, dma_p1_reads_en, p1_cmd_full, p1_rd_data, p1_rd_empty, p1_rd_error,
        input  dma_p1_ob_we, cmd, cmd_index, fetch_err,
               p1_cmd_en, p1_cmd_instr, p1_cmd_bl, p1_cmd_byte_addr, p1_rd_en
    );
endinterface

// File: rtl/cmd_fetch.sv
// Command-word fetcher: one read burst per sequencer request, words streamed
// to the sequencer with one strobe each, then advance to the next command slot.
module cmd_fetch #(
    parameter int unsigned CMD_BURST_LEN = 8,
    parameter logic [29:0] CMD_BASE_ADDR = 30'h000_0000,
    parameter logic [6:0]  CMD_MAX       = 7'd127
) (
    input  logic         clk,
    input  logic         rst,
    cmd_fetch_if.master  bus
);
    localparam logic [6:0]  LAST_WORD  = 7'(CMD_BURST_LEN - 1);
    localparam logic [29:0] SLOT_BYTES = 30'(CMD_BURST_LEN * 4);

    typedef enum logic [1:0] {IDLE, REQ, STREAM, HOLD} state_t;

    state_t      r_state;
    logic [6:0]  r_cmd_index;
    logic [6:0]  r_word_cnt;
    logic [31:0] r_cmd;
    logic [29:0] r_addr;
    logic        r_ob_we;
    logic        r_cmd_en;
    logic        r_fetch_err;
    logic        w_pop;

    assign w_pop = (r_state == STREAM) && !bus.p1_rd_empty;

    assign bus.p1_rd_en         = w_pop;
    assign bus.p1_cmd_instr     = 3'b001;
    assign bus.p1_cmd_bl        = 6'(CMD_BURST_LEN - 1);
    assign bus.p1_cmd_byte_addr = r_addr;
    assign bus.p1_cmd_en        = r_cmd_en;
    assign bus.dma_p1_ob_we     = r_ob_we;
    assign bus.cmd              = r_cmd;
    assign bus.cmd_index        = r_cmd_index;
    assign bus.fetch_err        = r_fetch_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cmd_index <= '0;
            r_word_cnt  <= '0;
            r_cmd       <= '0;
            r_addr      <= '0;
            r_ob_we     <= 1'b0;
            r_cmd_en    <= 1'b0;
            r_fetch_err <= 1'b0;
        end else begin
            r_ob_we <= 1'b0;
            if (bus.p1_rd_error) begin
                r_fetch_err <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (!bus.op_en) begin
                        r_cmd_index <= '0;
                    end else if (bus.dma_p1_reads_en) begin
                        r_state  <= REQ;
                        r_addr   <= CMD_BASE_ADDR + 30'(r_cmd_index) * SLOT_BYTES;
                        r_cmd_en <= !bus.p1_cmd_full;
                    end
                end
                // p1_cmd_en is registered: it is raised for the cycle after full
                // was seen clear, and reissued if full rose in that same cycle.
                REQ: begin
                    if (r_cmd_en && !bus.p1_cmd_full) begin
                        r_cmd_en   <= 1'b0;
                        r_word_cnt <= '0;
                        r_state    <= STREAM;
                    end else begin
                        r_cmd_en <= !bus.p1_cmd_full;
                    end
                end
                STREAM: begin
                    if (w_pop) begin
                        r_cmd      <= bus.p1_rd_data;
                        r_ob_we    <= 1'b1;
                        r_word_cnt <= r_word_cnt + 7'd1;
                        if (r_word_cnt == LAST_WORD) begin
                            r_cmd_index <= (r_cmd_index == CMD_MAX) ? '0 : r_cmd_index + 7'd1;
                            r_state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!bus.dma_p1_reads_en) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
